md_run_sequencer: RTL and testbench
===================================

Name: md_run_sequencer

Overview:
- Iteration scheduler for the MD datapath wrapper.
- Takes the run command and configuration from the AXI-Lite register block (start, iteration target, initial step) and sequences the phases: particle init load, force computation, motion update.
- Counts steps, drives the done/idle status and a per-phase timeout watchdog.
- Arbitrates host debug element read/write access to particle memory, so debug access happens only while no run is active.

Parameters:
- STEP_WIDTH, 32, width of step counter, iter_target and init_step.
- TIMEOUT_CYCLES, 1048576, maximum cycles spent waiting in any one phase before error.
- TMO_WIDTH, 21, width of the watchdog counter; must satisfy 2**TMO_WIDTH > TIMEOUT_CYCLES.

Ports:
- ap_clk  in  1  system clock.
- ap_rst_n  in  1  asynchronous active-low reset.
- ap_start  in  1  run request level from register block; acted on at its rising edge.
- iter_target  in  STEP_WIDTH  number of iterations to run.
- init_step  in  STEP_WIDTH  step value loaded at run start.
- sw_abort  in  1  synchronous soft abort.
- init_req  out  1  request particle init load.
- init_ack  in  1  init load complete.
- frc_start  out  1  1-cycle force-phase start pulse.
- frc_done  in  1  force phase complete pulse.
- mu_start  out  1  1-cycle motion-update start pulse.
- mu_done  in  1  motion update complete pulse.
- dbg_req  in  1  host debug element-access request (level).
- dbg_grant  out  1  debug access granted.
- ap_done  out  1  1-cycle pulse at run completion.
- ap_idle  out  1  no run active.
- done  out  1  sticky run-complete flag.
- err_timeout  out  1  sticky watchdog error.
- step  out  STEP_WIDTH  current step value.
- md_state  out  3  state encoding for the status register.

Behaviour:
- Reset values: all outputs 0, except ap_idle=1 and md_state=IDLE. step=0; iteration counter=0; start-edge register=0.
- State encoding: IDLE=0, INIT=1, FORCE=2, MOTION=3, DONE=4, ERROR=5.
- ap_idle=1 in IDLE, DONE and ERROR.
- Start detection: start_edge = ap_start & ~ap_start_q.
  - The edge is latched as pending and consumed only in IDLE or DONE while dbg_grant=0.
  - An edge seen in any other state or during a debug grant stays pending; it does not trigger a second run during an active one, and a new edge while pending is a no-op.
- IDLE/DONE on consumed start:
  - step<=init_step, iter_cnt<=0, done<=0, go to INIT.
  - If iter_target==0, go to DONE directly: ap_done pulses the next cycle, done=1, step=init_step.
- INIT:
  - init_req=1 held until init_ack=1; init_ack on the first cycle of INIT is accepted.
  - Next state FORCE.
- FORCE:
  - frc_start pulses on the entry cycle only.
  - frc_done is accepted only from the cycle after the pulse; a frc_done on the pulse cycle is ignored.
  - On accepted frc_done go to MOTION.
- MOTION:
  - Same pulse/accept rule using mu_start and mu_done.
  - On accepted mu_done: step<=step+1 (modulo 2**STEP_WIDTH, wraps silently), iter_cnt<=iter_cnt+1.
  - If iter_cnt+1==iter_target go to DONE, else go to FORCE.
- DONE entry: ap_done=1 for exactly one cycle; done=1 until the next consumed start or sw_abort.
- Watchdog:
  - Counter clears on every state transition and counts while in INIT, FORCE or MOTION.
  - When it reaches TIMEOUT_CYCLES without the awaited handshake: go to ERROR, err_timeout=1, init_req=0.
  - ERROR is left only by sw_abort.
- sw_abort, highest priority, any state: next state IDLE; done, err_timeout, init_req, dbg_grant and pending start are cleared; step holds its value.
- Debug arbitration:
  - dbg_grant rises one cycle after dbg_req is sampled high while ap_idle=1 and no start is being consumed that cycle.
  - It stays high while dbg_req=1 and drops the cycle after dbg_req falls.
  - Start has priority over a new request in the same cycle.
- Asynchronous reset mid-run: immediate return to the reset values; any in-flight datapath phase is abandoned.

Decomposition:
- Shared package md_pkg holds:
  - state enum md_state_e (3 bits), reused by the register block's status readback;
  - STEP_WIDTH default;
  - TIMEOUT_CYCLES default.
- One sub-module, md_phase_watchdog: loadable counter with clear, enable and TIMEOUT compare, producing a timeout pulse.

Test Plan:
- init_step=100, iter_target=3; ack each phase after 5 cycles -> 3 frc_start and 3 mu_start pulses, step ends 103, single ap_done pulse, done=1, md_state=4.
- iter_target=0, start -> DONE two cycles after the edge, no init_req/frc_start, step=init_step, ap_done pulse.
- init_step=0xFFFFFFFF, iter_target=2 -> step wraps to 0x00000001, no error.
- TIMEOUT_CYCLES=16, withhold frc_done -> ERROR after 16 cycles in FORCE, err_timeout=1, ap_idle=1; sw_abort -> IDLE, err_timeout=0.
- dbg_req high in IDLE, then ap_start edge -> grant held, run deferred; dbg_req low -> grant drops, next cycle run starts (INIT).
- frc_done asserted on the frc_start cycle -> ignored, stays in FORCE until a later frc_done; ap_rst_n low mid-MOTION -> all outputs reset immediately.

Source files
------------

// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared state encoding and defaults for the MD run sequencer
package md_pkg;

  // Encoding is also read back through the register block status word
  typedef enum logic [2:0] {
    MD_IDLE   = 3'd0,
    MD_INIT   = 3'd1,
    MD_FORCE  = 3'd2,
    MD_MOTION = 3'd3,
    MD_DONE   = 3'd4,
    MD_ERROR  = 3'd5
  } md_state_e;

  localparam int MD_STEP_WIDTH     = 32;
  localparam int MD_TIMEOUT_CYCLES = 1048576;
  localparam int MD_TMO_WIDTH      = 21;

  function automatic logic md_is_idle(input md_state_e s);
    return (s == MD_IDLE) || (s == MD_DONE) || (s == MD_ERROR);
  endfunction

endpackage

// File: rtl/md_run_sequencer_if.sv
// rtl/md_run_sequencer_if.sv - phase handshakes between sequencer and MD datapath
interface md_run_sequencer_if;

  logic init_req;
  logic init_ack;
  logic frc_start;
  logic frc_done;
  logic mu_start;
  logic mu_done;

  modport master (
    output init_req, frc_start, mu_start,
    input  init_ack, frc_done, mu_done
  );

  modport slave (
    input  init_req, frc_start, mu_start,
    output init_ack, frc_done, mu_done
  );

endinterface

// File: rtl/md_phase_watchdog.sv
// rtl/md_phase_watchdog.sv - per-phase cycle counter with timeout compare
module md_phase_watchdog #(
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int TMO_WIDTH      = 21
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 ld,
  input  logic [TMO_WIDTH-1:0] ld_val,
  input  logic                 en,
  output logic                 timeout
);

  logic [TMO_WIDTH-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (ld) begin
      cnt <= ld_val;
    end else if (en) begin
      cnt <= cnt + TMO_WIDTH'(1);
    end
  end

  // Fires during the TIMEOUT_CYCLES-th enabled cycle; must not depend on clr
  assign timeout = en && (cnt == TMO_WIDTH'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/md_run_sequencer.sv
// rtl/md_run_sequencer.sv - MD iteration scheduler with watchdog and debug arbitration
module md_run_sequencer
  import md_pkg::*;
#(
  parameter int STEP_WIDTH     = MD_STEP_WIDTH,
  parameter int TIMEOUT_CYCLES = MD_TIMEOUT_CYCLES,
  parameter int TMO_WIDTH      = MD_TMO_WIDTH
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ap_start,
  input  logic [STEP_WIDTH-1:0] iter_target,
  input  logic [STEP_WIDTH-1:0] init_step,
  input  logic                  sw_abort,
  md_run_sequencer_if.master    dp,
  input  logic                  dbg_req,
  output logic                  dbg_grant,
  output logic                  ap_done,
  output logic                  ap_idle,
  output logic                  done,
  output logic                  err_timeout,
  output logic [STEP_WIDTH-1:0] step,
  output logic [2:0]            md_state
);

  md_state_e             state, state_d;
  logic                  ap_start_q, start_edge, start_pend, consume;
  logic                  phase_first, frc_ok, mu_ok, last_iter, in_phase, tmo;
  logic                  done_enter, err_enter;
  logic [STEP_WIDTH-1:0] iter_cnt;

  assign start_edge = ap_start && !ap_start_q;
  assign ap_idle    = md_is_idle(state);
  assign consume    = start_pend && (state == MD_IDLE || state == MD_DONE) &&
                      !dbg_grant && !sw_abort;

  // Completion on the start-pulse cycle belongs to a previous phase and is dropped
  assign frc_ok    = (state == MD_FORCE)  && !phase_first && dp.frc_done;
  assign mu_ok     = (state == MD_MOTION) && !phase_first && dp.mu_done;
  assign last_iter = (iter_cnt + STEP_WIDTH'(1)) == iter_target;
  assign in_phase  = (state == MD_INIT) || (state == MD_FORCE) || (state == MD_MOTION);

  assign dp.init_req  = (state == MD_INIT);
  assign dp.frc_start = (state == MD_FORCE)  && phase_first;
  assign dp.mu_start  = (state == MD_MOTION) && phase_first;
  assign md_state     = state;

  md_phase_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TMO_WIDTH      (TMO_WIDTH)
  ) u_watchdog (
    .clk     (ap_clk),
    .rst_n   (ap_rst_n),
    .clr     (state_d != state),
    .ld      (1'b0),
    .ld_val  ('0),
    .en      (in_phase),
    .timeout (tmo)
  );

  always_comb begin
    state_d    = state;
    done_enter = 1'b0;
    err_enter  = 1'b0;
    case (state)
      MD_IDLE, MD_DONE: begin
        if (consume) begin
          if (iter_target == '0) begin
            state_d    = MD_DONE;
            done_enter = 1'b1;
          end else begin
            state_d = MD_INIT;
          end
        end
      end
      MD_INIT: begin
        if (dp.init_ack) begin
          state_d = MD_FORCE;
        end else if (tmo) begin
          state_d   = MD_ERROR;
          err_enter = 1'b1;
        end
      end
      MD_FORCE: begin
        if (frc_ok) begin
          state_d = MD_MOTION;
        end else if (tmo) begin
          state_d   = MD_ERROR;
          err_enter = 1'b1;
        end
      end
      MD_MOTION: begin
        if (mu_ok) begin
          state_d    = last_iter ? MD_DONE : MD_FORCE;
          done_enter = last_iter;
        end else if (tmo) begin
          state_d   = MD_ERROR;
          err_enter = 1'b1;
        end
      end
      MD_ERROR: state_d = MD_ERROR;
      default:  state_d = MD_IDLE;
    endcase
    if (sw_abort) begin
      state_d    = MD_IDLE;
      done_enter = 1'b0;
      err_enter  = 1'b0;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state       <= MD_IDLE;
      ap_start_q  <= 1'b0;
      start_pend  <= 1'b0;
      phase_first <= 1'b0;
      step        <= '0;
      iter_cnt    <= '0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
      dbg_grant   <= 1'b0;
      ap_done     <= 1'b0;
    end else begin
      state       <= state_d;
      ap_start_q  <= ap_start;
      phase_first <= (state_d != state);
      ap_done     <= done_enter;

      // Edges arriving while a start is already pending are absorbed
      if (sw_abort || consume) begin
        start_pend <= 1'b0;
      end else if (start_edge) begin
        start_pend <= 1'b1;
      end

      if (consume) begin
        step     <= init_step;
        iter_cnt <= '0;
      end else if (mu_ok && !sw_abort) begin
        step     <= step + STEP_WIDTH'(1);
        iter_cnt <= iter_cnt + STEP_WIDTH'(1);
      end

      if (sw_abort) begin
        done <= 1'b0;
      end else if (done_enter) begin
        done <= 1'b1;
      end else if (consume) begin
        done <= 1'b0;
      end

      if (sw_abort) begin
        err_timeout <= 1'b0;
      end else if (err_enter) begin
        err_timeout <= 1'b1;
      end

      if (sw_abort) begin
        dbg_grant <= 1'b0;
      end else if (dbg_grant) begin
        dbg_grant <= dbg_req;
      end else begin
        dbg_grant <= dbg_req && ap_idle && !consume;
      end
    end
  end

endmodule

// File: tb/tb_md_run_sequencer.sv
// tb/tb_md_run_sequencer.sv - directed self-checking bench for md_run_sequencer
`timescale 1ns/1ps
module tb_md_run_sequencer;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b1;
  logic        ap_start = 1'b0;
  logic        sw_abort = 1'b0;
  logic        dbg_req = 1'b0;
  logic [31:0] iter_target = '0;
  logic [31:0] init_step = '0;
  logic        dbg_grant, ap_done, ap_idle, done, err_timeout;
  logic [31:0] step;
  logic [2:0]  md_state;

  int vecs = 0;
  int miss = 0;
  int n_frc = 0;
  int n_mu = 0;
  int n_apd = 0;
  int n_init = 0;

  md_run_sequencer_if dp_if ();

  md_run_sequencer #(
    .STEP_WIDTH     (32),
    .TIMEOUT_CYCLES (16),
    .TMO_WIDTH      (5)
  ) dut (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .ap_start    (ap_start),
    .iter_target (iter_target),
    .init_step   (init_step),
    .sw_abort    (sw_abort),
    .dp          (dp_if),
    .dbg_req     (dbg_req),
    .dbg_grant   (dbg_grant),
    .ap_done     (ap_done),
    .ap_idle     (ap_idle),
    .done        (done),
    .err_timeout (err_timeout),
    .step        (step),
    .md_state    (md_state)
  );

  always #5 ap_clk = ~ap_clk;

  always @(negedge ap_clk) begin
    if (dp_if.frc_start) n_frc++;
    if (dp_if.mu_start)  n_mu++;
    if (ap_done)         n_apd++;
    if (dp_if.init_req)  n_init++;
  end

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic ack_init(input int w);
    repeat (w) tick();
    dp_if.init_ack = 1'b1;
    tick();
    dp_if.init_ack = 1'b0;
  endtask

  task automatic ack_frc(input int w);
    repeat (w) tick();
    dp_if.frc_done = 1'b1;
    tick();
    dp_if.frc_done = 1'b0;
  endtask

  task automatic ack_mu(input int w);
    repeat (w) tick();
    dp_if.mu_done = 1'b1;
    tick();
    dp_if.mu_done = 1'b0;
  endtask

  task automatic start_run();
    ap_start = 1'b1;
    tick();
    tick();
    ap_start = 1'b0;
  endtask

  task automatic test_reset();
    vecs++; if (ap_idle !== 1'b1) begin miss++; $display("FAIL reset_idle actual=%b required=1", ap_idle); end
    vecs++; if (md_state !== 3'd0) begin miss++; $display("FAIL reset_state actual=%0d required=0", md_state); end
    vecs++; if (step !== 32'd0) begin miss++; $display("FAIL reset_step actual=%0h required=0", step); end
    vecs++;
    if ({dp_if.init_req, dp_if.frc_start, dp_if.mu_start, ap_done, done, err_timeout, dbg_grant} !== 7'd0) begin
      miss++; $display("FAIL reset_outputs actual=%b required=0000000",
        {dp_if.init_req, dp_if.frc_start, dp_if.mu_start, ap_done, done, err_timeout, dbg_grant});
    end
  endtask

  task automatic test_three_iter();
    int f0, m0, a0;
    iter_target = 32'd3;
    init_step   = 32'd100;
    f0 = n_frc; m0 = n_mu; a0 = n_apd;
    start_run();
    vecs++; if (md_state !== 3'd1 || dp_if.init_req !== 1'b1) begin miss++; $display("FAIL run_init actual=%0d/%b required=1/1", md_state, dp_if.init_req); end
    vecs++; if (ap_idle !== 1'b0) begin miss++; $display("FAIL run_idle actual=%b required=0", ap_idle); end
    ack_init(4);
    for (int i = 0; i < 3; i++) begin
      vecs++; if (dp_if.frc_start !== 1'b1 || md_state !== 3'd2) begin miss++; $display("FAIL run_force%0d actual=%b/%0d required=1/2", i, dp_if.frc_start, md_state); end
      ack_frc(4);
      vecs++; if (dp_if.mu_start !== 1'b1 || md_state !== 3'd3) begin miss++; $display("FAIL run_motion%0d actual=%b/%0d required=1/3", i, dp_if.mu_start, md_state); end
      ack_mu(4);
      vecs++; if (step !== 32'd101 + 32'(i)) begin miss++; $display("FAIL run_step%0d actual=%0d required=%0d", i, step, 101 + i); end
    end
    vecs++; if (md_state !== 3'd4 || ap_done !== 1'b1 || done !== 1'b1) begin miss++; $display("FAIL run_done actual=%0d/%b/%b required=4/1/1", md_state, ap_done, done); end
    tick();
    vecs++; if (ap_done !== 1'b0 || done !== 1'b1) begin miss++; $display("FAIL run_done_hold actual=%b/%b required=0/1", ap_done, done); end
    vecs++; if (n_frc - f0 !== 3 || n_mu - m0 !== 3) begin miss++; $display("FAIL run_pulses actual=%0d/%0d required=3/3", n_frc - f0, n_mu - m0); end
    vecs++; if (n_apd - a0 !== 1) begin miss++; $display("FAIL run_ap_done_count actual=%0d required=1", n_apd - a0); end
  endtask

  task automatic test_zero_target();
    int i0, f0, a0;
    iter_target = 32'd0;
    init_step   = 32'd55;
    i0 = n_init; f0 = n_frc; a0 = n_apd;
    ap_start = 1'b1;
    tick();
    vecs++; if (ap_done !== 1'b0) begin miss++; $display("FAIL zero_early actual=%b required=0", ap_done); end
    tick();
    ap_start = 1'b0;
    vecs++; if (md_state !== 3'd4 || ap_done !== 1'b1 || done !== 1'b1) begin miss++; $display("FAIL zero_done actual=%0d/%b/%b required=4/1/1", md_state, ap_done, done); end
    vecs++; if (step !== 32'd55) begin miss++; $display("FAIL zero_step actual=%0d required=55", step); end
    tick();
    vecs++; if (n_init - i0 !== 0 || n_frc - f0 !== 0 || n_apd - a0 !== 1) begin
      miss++; $display("FAIL zero_pulses actual=%0d/%0d/%0d required=0/0/1", n_init - i0, n_frc - f0, n_apd - a0);
    end
  endtask

  task automatic test_wrap();
    iter_target = 32'd2;
    init_step   = 32'hFFFF_FFFF;
    start_run();
    ack_init(0);
    ack_frc(1);
    ack_mu(1);
    vecs++; if (step !== 32'd0 || md_state !== 3'd2) begin miss++; $display("FAIL wrap_first actual=%0h/%0d required=0/2", step, md_state); end
    ack_frc(1);
    ack_mu(1);
    vecs++; if (step !== 32'd1 || md_state !== 3'd4 || err_timeout !== 1'b0) begin
      miss++; $display("FAIL wrap_done actual=%0h/%0d/%b required=1/4/0", step, md_state, err_timeout);
    end
  endtask

  task automatic test_timeout();
    iter_target = 32'd1;
    init_step   = 32'd7;
    start_run();
    ack_init(0);
    repeat (15) tick();
    vecs++; if (md_state !== 3'd2) begin miss++; $display("FAIL tmo_before actual=%0d required=2", md_state); end
    tick();
    vecs++; if (md_state !== 3'd5 || err_timeout !== 1'b1 || done !== 1'b0) begin miss++; $display("FAIL tmo_error actual=%0d/%b/%b required=5/1/0", md_state, err_timeout, done); end
    vecs++; if (ap_idle !== 1'b1 || dp_if.init_req !== 1'b0) begin miss++; $display("FAIL tmo_idle actual=%b/%b required=1/0", ap_idle, dp_if.init_req); end
    tick();
    vecs++; if (md_state !== 3'd5) begin miss++; $display("FAIL tmo_hold actual=%0d required=5", md_state); end
    sw_abort = 1'b1;
    tick();
    sw_abort = 1'b0;
    vecs++; if (md_state !== 3'd0 || err_timeout !== 1'b0 || step !== 32'd7) begin
      miss++; $display("FAIL tmo_abort actual=%0d/%b/%0d required=0/0/7", md_state, err_timeout, step);
    end
  endtask

  task automatic test_dbg();
    dbg_req = 1'b1;
    tick();
    vecs++; if (dbg_grant !== 1'b1) begin miss++; $display("FAIL dbg_grant actual=%b required=1", dbg_grant); end
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    tick();
    tick();
    vecs++; if (md_state !== 3'd0 || dbg_grant !== 1'b1) begin miss++; $display("FAIL dbg_defer actual=%0d/%b required=0/1", md_state, dbg_grant); end
    dbg_req = 1'b0;
    tick();
    vecs++; if (md_state !== 3'd0 || dbg_grant !== 1'b0) begin miss++; $display("FAIL dbg_release actual=%0d/%b required=0/0", md_state, dbg_grant); end
    tick();
    vecs++; if (md_state !== 3'd1 || dp_if.init_req !== 1'b1) begin miss++; $display("FAIL dbg_run actual=%0d/%b required=1/1", md_state, dp_if.init_req); end
    sw_abort = 1'b1;
    tick();
    sw_abort = 1'b0;
    ap_start = 1'b1;
    tick();
    dbg_req = 1'b1;
    tick();
    ap_start = 1'b0;
    vecs++; if (md_state !== 3'd1 || dbg_grant !== 1'b0) begin miss++; $display("FAIL dbg_start_prio actual=%0d/%b required=1/0", md_state, dbg_grant); end
    tick();
    vecs++; if (dbg_grant !== 1'b0) begin miss++; $display("FAIL dbg_busy actual=%b required=0", dbg_grant); end
    dbg_req  = 1'b0;
    sw_abort = 1'b1;
    tick();
    sw_abort = 1'b0;
  endtask

  task automatic test_early_done_reset();
    iter_target = 32'd2;
    init_step   = 32'd9;
    start_run();
    ack_init(0);
    dp_if.frc_done = 1'b1;
    tick();
    dp_if.frc_done = 1'b0;
    vecs++; if (md_state !== 3'd2 || dp_if.frc_start !== 1'b0) begin miss++; $display("FAIL early_ignored actual=%0d/%b required=2/0", md_state, dp_if.frc_start); end
    tick();
    vecs++; if (md_state !== 3'd2) begin miss++; $display("FAIL early_hold actual=%0d required=2", md_state); end
    ack_frc(1);
    vecs++; if (md_state !== 3'd3 || dp_if.mu_start !== 1'b1) begin miss++; $display("FAIL early_motion actual=%0d/%b required=3/1", md_state, dp_if.mu_start); end
    tick();
    ap_rst_n = 1'b0;
    #1;
    vecs++; if (md_state !== 3'd0 || ap_idle !== 1'b1 || step !== 32'd0) begin miss++; $display("FAIL async_reset actual=%0d/%b/%0d required=0/1/0", md_state, ap_idle, step); end
    vecs++; if ({dp_if.init_req, dp_if.frc_start, dp_if.mu_start, ap_done, done, err_timeout, dbg_grant} !== 7'd0) begin
      miss++; $display("FAIL async_reset_outputs actual=%b required=0000000",
        {dp_if.init_req, dp_if.frc_start, dp_if.mu_start, ap_done, done, err_timeout, dbg_grant});
    end
    tick();
    ap_rst_n = 1'b1;
    tick();
    vecs++; if (md_state !== 3'd0 || step !== 32'd0) begin miss++; $display("FAIL post_reset actual=%0d/%0d required=0/0", md_state, step); end
  endtask

  initial begin
    dp_if.init_ack = 1'b0;
    dp_if.frc_done = 1'b0;
    dp_if.mu_done  = 1'b0;
    #2;
    ap_rst_n = 1'b0;
    repeat (3) tick();
    test_reset();
    ap_rst_n = 1'b1;
    tick();
    test_three_iter();
    test_zero_target();
    test_wrap();
    test_timeout();
    test_dbg();
    test_early_done_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
